// File: rtl/board_pkg.sv
// rtl/board_pkg.sv - shared types, constants and sizing helper for the board frame transmitter
package board_pkg;

   typedef enum logic [1:0] {
      CELL_EMPTY   = 2'b00,
      CELL_BLACK   = 2'b01,
      CELL_WHITE   = 2'b10,
      CELL_ILLEGAL = 2'b11
   } cell_t;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_SYNC,
      ST_DIM,
      ST_PAYLOAD,
      ST_CSUM
   } frame_state_t;

   localparam logic [7:0] SYNC_BYTE_DEFAULT = 8'hA5;
   localparam int         CELL_BITS         = 2;

   // Four 2-bit cells per payload byte, last byte zero-padded.
   function automatic int npay(input int dim);
      return (dim * dim + 3) / 4;
   endfunction

endpackage

// File: rtl/board_byte_pack.sv
// rtl/board_byte_pack.sv - picks the four cells of payload byte idx_in from the snapshot, zero-padded
module board_byte_pack
   import board_pkg::*;
#(
   parameter int BOARD_DIM = 9
) (
   input  logic [BOARD_DIM*BOARD_DIM*CELL_BITS-1:0] snap_in,
   input  logic [$clog2(npay(BOARD_DIM))-1:0]      idx_in,
   output logic [7:0]                               byte_out
);

   localparam int NCELLS = BOARD_DIM * BOARD_DIM;
   localparam int IDX_W  = $clog2(npay(BOARD_DIM));
   localparam int NB     = 2 ** IDX_W;

   // Table padded to a power of two so every index value selects a defined byte.
   logic [NB-1:0][7:0] bytes;

   for (genvar k = 0; k < NB; k++) begin : g_byte
      for (genvar j = 0; j < 4; j++) begin : g_cell
         if (4 * k + j < NCELLS) begin : g_live
            assign bytes[k][2*j +: 2] = snap_in[(4*k+j)*CELL_BITS +: CELL_BITS];
         end else begin : g_pad
            assign bytes[k][2*j +: 2] = CELL_EMPTY;
         end
      end
   end

   assign byte_out = bytes[idx_in];

endmodule

// File: rtl/board_frame_tx.sv
// rtl/board_frame_tx.sv - serialises a board snapshot as SYNC, DIM, payload, XOR checksum over valid/ready
module board_frame_tx
   import board_pkg::*;
#(
   parameter int         BOARD_DIM = 9,
   parameter int         CELL_W    = 2,
   parameter logic [7:0] SYNC_BYTE = SYNC_BYTE_DEFAULT
) (
   input  logic                                 clk_in,
   input  logic                                 rst_n_in,
   input  logic [BOARD_DIM*BOARD_DIM*CELL_W-1:0] board_in,
   input  logic                                 start_in,
   input  logic                                 abort_in,
   output logic [7:0]                           tx_data_out,
   output logic                                 tx_valid_out,
   input  logic                                 tx_ready_in,
   output logic                                 tx_last_out,
   output logic                                 busy_out,
   output logic                                 done_out,
   output logic                                 illegal_out
);

   localparam int         NCELLS   = BOARD_DIM * BOARD_DIM;
   localparam int         NPAY     = npay(BOARD_DIM);
   localparam int         IDX_W    = $clog2(NPAY);
   localparam int         SNAP_W   = NCELLS * CELL_W;
   localparam logic [7:0] DIM_BYTE = 8'(BOARD_DIM);

   frame_state_t      state_q, state_d;
   logic [SNAP_W-1:0] snap_q, snap_d;
   logic [IDX_W-1:0]  cnt_q, cnt_d;
   logic [7:0]        csum_q, csum_d;
   logic [7:0]        data_q, data_d;
   logic              valid_q, valid_d;
   logic              last_q, last_d;
   logic              done_q, done_d;
   logic              illegal_q, illegal_d;

   logic [NCELLS-1:0] cell_ill;
   logic [IDX_W-1:0]  pack_idx;
   logic [7:0]        pack_byte;
   logic              hs;

   for (genvar i = 0; i < NCELLS; i++) begin : g_ill
      assign cell_ill[i] = (board_in[i*CELL_W +: CELL_W] == CELL_ILLEGAL);
   end

   // Look ahead one byte so the next payload byte is ready on the accepting edge.
   assign pack_idx = (state_q == ST_PAYLOAD) ? cnt_q + IDX_W'(1) : '0;
   assign hs       = valid_q & tx_ready_in;

   board_byte_pack #(
      .BOARD_DIM (BOARD_DIM)
   ) u_pack (
      .snap_in  (snap_q),
      .idx_in   (pack_idx),
      .byte_out (pack_byte)
   );

   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         state_q   <= ST_IDLE;
         snap_q    <= '0;
         cnt_q     <= '0;
         csum_q    <= '0;
         data_q    <= '0;
         valid_q   <= 1'b0;
         last_q    <= 1'b0;
         done_q    <= 1'b0;
         illegal_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         snap_q    <= snap_d;
         cnt_q     <= cnt_d;
         csum_q    <= csum_d;
         data_q    <= data_d;
         valid_q   <= valid_d;
         last_q    <= last_d;
         done_q    <= done_d;
         illegal_q <= illegal_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      snap_d    = snap_q;
      cnt_d     = cnt_q;
      csum_d    = csum_q;
      data_d    = data_q;
      valid_d   = valid_q;
      last_d    = last_q;
      done_d    = 1'b0;
      illegal_d = illegal_q;

      if (state_q != ST_IDLE && abort_in) begin
         state_d = ST_IDLE;
         cnt_d   = '0;
         csum_d  = '0;
         data_d  = '0;
         valid_d = 1'b0;
         last_d  = 1'b0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               // Starts are held off during the done pulse cycle.
               if (start_in && !done_q) begin
                  snap_d    = board_in;
                  illegal_d = |cell_ill;
                  state_d   = ST_SYNC;
                  data_d    = SYNC_BYTE;
                  valid_d   = 1'b1;
                  last_d    = 1'b0;
               end
            end
            ST_SYNC: begin
               if (hs) begin
                  state_d = ST_DIM;
                  data_d  = DIM_BYTE;
               end
            end
            ST_DIM: begin
               if (hs) begin
                  state_d = ST_PAYLOAD;
                  cnt_d   = '0;
                  csum_d  = DIM_BYTE;
                  data_d  = pack_byte;
               end
            end
            ST_PAYLOAD: begin
               if (hs) begin
                  csum_d = csum_q ^ data_q;
                  if (cnt_q == IDX_W'(NPAY - 1)) begin
                     state_d = ST_CSUM;
                     cnt_d   = '0;
                     data_d  = csum_q ^ data_q;
                     last_d  = 1'b1;
                  end else begin
                     cnt_d  = cnt_q + IDX_W'(1);
                     data_d = pack_byte;
                  end
               end
            end
            ST_CSUM: begin
               if (hs) begin
                  state_d = ST_IDLE;
                  csum_d  = '0;
                  data_d  = '0;
                  valid_d = 1'b0;
                  last_d  = 1'b0;
                  done_d  = 1'b1;
               end
            end
            default: state_d = ST_IDLE;
         endcase
      end
   end

   assign tx_data_out  = data_q;
   assign tx_valid_out = valid_q;
   assign tx_last_out  = last_q;
   assign busy_out     = (state_q != ST_IDLE);
   assign done_out     = done_q;
   assign illegal_out  = illegal_q;

endmodule

// File: tb/tb_board_frame_tx.sv
// tb/tb_board_frame_tx.sv - scoreboard bench for board_frame_tx at BOARD_DIM 9 and 19
module tb_board_frame_tx;

   typedef struct packed {
      logic [7:0] d;
      logic       l;
   } exp_t;

   logic         clk = 1'b0;
   logic         rst_n;

   logic [161:0] board9;
   logic         start9, abort9;
   logic         ready9 = 1'b1;
   logic [7:0]   data9;
   logic         valid9, last9, busy9, done9, ill9;

   logic [721:0] board19;
   logic         start19, abort19, ready19;
   logic [7:0]   data19;
   logic         valid19, last19, busy19, done19, ill19;

   exp_t         q9[$];
   exp_t         q19[$];
   int           n_chk  = 0;
   int           n_fail = 0;
   int           tot9   = 0;
   int           base9  = 0;
   int           rmode  = 0;
   int           stall_cnt = 0;
   bit           stall9 = 0, exp_done9 = 0, exp_done19 = 0;
   logic [7:0]   hold9 = 8'h00;

   always #5 clk = ~clk;

   board_frame_tx #(.BOARD_DIM(9)) dut9 (
      .clk_in(clk), .rst_n_in(rst_n), .board_in(board9), .start_in(start9),
      .abort_in(abort9), .tx_data_out(data9), .tx_valid_out(valid9),
      .tx_ready_in(ready9), .tx_last_out(last9), .busy_out(busy9),
      .done_out(done9), .illegal_out(ill9)
   );

   board_frame_tx #(.BOARD_DIM(19)) dut19 (
      .clk_in(clk), .rst_n_in(rst_n), .board_in(board19), .start_in(start19),
      .abort_in(abort19), .tx_data_out(data19), .tx_valid_out(valid19),
      .tx_ready_in(ready19), .tx_last_out(last19), .busy_out(busy19),
      .done_out(done19), .illegal_out(ill19)
   );

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
      end
   endtask

   // Pushes the first nbytes of a frame whose payload is zero except byte pidx.
   task automatic push_frame(input bit sel19, input int dim, input int np, input int pidx,
                             input logic [7:0] pval, input logic [7:0] csum, input int nbytes);
      exp_t e;
      for (int i = 0; i < nbytes; i++) begin
         e.l = 1'b0;
         if (i == 0)           e.d = 8'hA5;
         else if (i == 1)      e.d = dim[7:0];
         else if (i == np + 2) begin e.d = csum; e.l = 1'b1; end
         else                  e.d = (i - 2 == pidx) ? pval : 8'h00;
         if (sel19) q19.push_back(e);
         else       q9.push_back(e);
      end
   endtask

   task automatic start_frame9(input bit hold);
      @(posedge clk); #1;
      base9  = tot9;
      start9 = 1'b1;
      @(posedge clk); #1;
      if (!hold) start9 = 1'b0;
      chk("start_latency_valid", valid9, 1);
   endtask

   task automatic wait_done(input bit sel19, input string nm);
      bit got = 0;
      for (int i = 0; i < 3000 && !got; i++) begin
         @(posedge clk); #1;
         got = sel19 ? done19 : done9;
      end
      if (!got) begin
         n_chk++; n_fail++;
         $display("FAIL %s: done_out not seen within cycle bound", nm);
      end
   endtask

   task automatic wait_acc9(input int n, input string nm);
      bit got = 0;
      for (int i = 0; i < 1000 && !got; i++) begin
         @(posedge clk); #1;
         got = (tot9 - base9) >= n;
      end
      if (!got) begin
         n_chk++; n_fail++;
         $display("FAIL %s: byte count %0d not reached within cycle bound", nm, n);
      end
   endtask

   // Ready driver: constant in mode 0; random with a 3-cycle stall on frame byte 7 in mode 1.
   always @(posedge clk) begin
      #1;
      if (rmode == 0) begin
         ready9    = 1'b1;
         stall_cnt = 0;
      end else if ((tot9 - base9) == 7 && stall_cnt < 3) begin
         ready9 = 1'b0;
         stall_cnt++;
      end else begin
         ready9 = 1'($urandom_range(0, 1));
      end
   end

   always @(negedge clk) begin
      exp_t e;
      if (!rst_n) begin
         stall9    = 0;
         exp_done9 = 0;
      end else begin
         if (exp_done9) begin
            chk("done9_pulse", done9, 1);
            exp_done9 = 0;
         end else if (done9) begin
            chk("done9_spurious", done9, 0);
         end
         if (stall9) begin
            chk("stall9_valid_held", valid9, 1);
            chk("stall9_data_held", data9, hold9);
         end
         if (valid9 && ready9) begin
            if (q9.size() == 0) begin
               chk("dut9_unexpected_byte", data9, 9'h100);
            end else begin
               e = q9.pop_front();
               chk("dut9_byte", data9, e.d);
               chk("dut9_last", last9, e.l);
               if (e.l) exp_done9 = 1;
            end
            tot9++;
         end
         stall9 = valid9 && !ready9;
         hold9  = data9;
      end
   end

   always @(negedge clk) begin
      exp_t e;
      if (!rst_n) begin
         exp_done19 = 0;
      end else begin
         if (exp_done19) begin
            chk("done19_pulse", done19, 1);
            exp_done19 = 0;
         end else if (done19) begin
            chk("done19_spurious", done19, 0);
         end
         if (valid19 && ready19) begin
            if (q19.size() == 0) begin
               chk("dut19_unexpected_byte", data19, 9'h100);
            end else begin
               e = q19.pop_front();
               chk("dut19_byte", data19, e.d);
               chk("dut19_last", last19, e.l);
               if (e.l) exp_done19 = 1;
            end
         end
      end
   end

   initial begin
      rst_n   = 1'b0;
      board9  = '0;  start9  = 1'b0; abort9  = 1'b0;
      board19 = '0;  start19 = 1'b0; abort19 = 1'b0; ready19 = 1'b1;
      #1;
      chk("reset_valid", valid9, 0);
      chk("reset_data", data9, 0);
      chk("reset_last", last9, 0);
      chk("reset_busy", busy9, 0);
      chk("reset_done", done9, 0);
      chk("reset_illegal", ill9, 0);
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;

      // Empty board, continuous ready
      push_frame(0, 9, 21, 0, 8'h00, 8'h09, 24);
      start_frame9(0);
      chk("empty_illegal", ill9, 0);
      wait_done(0, "empty_frame");
      chk("empty_busy_after", busy9, 0);

      // Single black stone at (0,0), then single white stone at (8,8)
      board9 = '0; board9[1:0] = 2'b01;
      push_frame(0, 9, 21, 0, 8'h01, 8'h08, 24);
      start_frame9(0);
      wait_done(0, "black00_frame");
      board9 = '0; board9[161:160] = 2'b10;
      push_frame(0, 9, 21, 20, 8'h02, 8'h0B, 24);
      start_frame9(0);
      wait_done(0, "white88_frame");

      // Random ready with a stall, board changed after capture
      board9 = '0;
      rmode  = 1;
      push_frame(0, 9, 21, 0, 8'h00, 8'h09, 24);
      start_frame9(0);
      repeat (2) @(posedge clk);
      #1 board9 = '1;
      wait_done(0, "backpressure_frame");
      rmode = 0;
      board9 = '0;

      // start held high for the whole frame
      push_frame(0, 9, 21, 0, 8'h00, 8'h09, 24);
      start_frame9(1);
      wait_done(0, "held_start_frame");
      start9 = 1'b0;
      repeat (4) @(posedge clk);
      #1;
      chk("held_start_single_frame_busy", busy9, 0);
      chk("held_start_single_frame_valid", valid9, 0);

      // Abort while payload byte 10 is on the bus (accepted the same cycle)
      push_frame(0, 9, 21, 0, 8'h00, 8'h09, 13);
      start_frame9(0);
      wait_acc9(12, "abort_setup");
      abort9 = 1'b1;
      @(posedge clk); #1;
      abort9 = 1'b0;
      chk("abort_valid_low", valid9, 0);
      chk("abort_busy_low", busy9, 0);
      chk("abort_queue_drained", q9.size(), 0);
      repeat (3) @(posedge clk);
      push_frame(0, 9, 21, 0, 8'h00, 8'h09, 24);
      start_frame9(0);
      wait_done(0, "post_abort_frame");

      // Illegal cell, then asynchronous reset mid-payload
      board9 = '0; board9[1:0] = 2'b11;
      push_frame(0, 9, 21, 0, 8'h03, 8'h0A, 8);
      start_frame9(0);
      chk("illegal_set", ill9, 1);
      wait_acc9(8, "reset_setup");
      rst_n = 1'b0;
      #1;
      chk("midreset_valid", valid9, 0);
      chk("midreset_data", data9, 0);
      chk("midreset_last", last9, 0);
      chk("midreset_busy", busy9, 0);
      chk("midreset_illegal", ill9, 0);
      chk("midreset_queue_drained", q9.size(), 0);
      @(posedge clk); #1;
      rst_n = 1'b1;

      // 19x19 board with an illegal cell at (18,18): 91 payload bytes
      board19 = '0; board19[721:720] = 2'b11;
      push_frame(1, 19, 91, 90, 8'h03, 8'h10, 94);
      @(posedge clk); #1;
      start19 = 1'b1;
      @(posedge clk); #1;
      start19 = 1'b0;
      chk("dim19_valid", valid19, 1);
      chk("dim19_illegal", ill19, 1);
      wait_done(1, "dim19_frame");
      chk("dim19_busy_after", busy19, 0);

      repeat (3) @(posedge clk);
      #1;
      chk("q9_empty_at_end", q9.size(), 0);
      chk("q19_empty_at_end", q19.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
